// File: rtl/latch_exerciser_if.sv
// Stimulus/response bundle between the exerciser and the lab latch/flip-flop top.
// master: exerciser side (drives s, r, d, g; samples the five storage outputs).
// slave: latch-top side (samples s, r, d, g on its ck input; drives the outputs).
interface latch_exerciser_if;
    logic s;        // set stimulus
    logic r;        // reset stimulus
    logic d;        // data stimulus
    logic g;        // gate/clock stimulus, wired to the latch top's ck input
    logic qa;       // SR latch Q
    logic qb;       // SR latch Q-bar
    logic q_lvl;    // level-sensitive (gated) SR latch output
    logic q_latch;  // transparent D latch output
    logic q_ff;     // D flip-flop output

    modport master (output s, r, d, g, input qa, qb, q_lvl, q_latch, q_ff);
    modport slave  (input s, r, d, g, output qa, qb, q_lvl, q_latch, q_ff);
endinterface

// File: rtl/latch_exerciser.sv
// Self-running stimulus generator and checker for the lab latch/flip-flop top.
// Latency: start sampled at edge t -> done at edge t + 4*2**IDX_W; each vector takes 4 ck cycles.
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while busy.
// Ports: ck/rst (sync, active-high) and start are plain; lab carries s/r/d/g out and
// qa/qb/q_lvl/q_latch/q_ff back; busy/done/pass, err_count (saturating),
// first_fail_valid/first_fail_idx and vec_idx report progress and results.
// IDX_W must be at least 4: the data pattern uses vector index bit 3.
module latch_exerciser #(
    parameter int IDX_W = 4,
    parameter int ERR_W = 8
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 start,
    latch_exerciser_if.master    lab,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 first_fail_valid,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic [IDX_W-1:0]     vec_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t     state;
    logic [1:0] phase;
    logic       m;          // expected SR storage value
    logic       mv;         // m is meaningful once any set or reset has been applied
    logic       fail;       // sticky mismatch for the current vector
    logic       s_q, r_q, d_q, g_q;
    logic       mism;

    // Stimulus {s, r, d} for a vector index; s and r can never both be 1.
    function automatic logic [2:0] stim(input logic [IDX_W-1:0] i);
        return {i[1] & ~i[2], i[2] & ~i[1], i[0] ^ i[3]};
    endfunction

    assign lab.s = s_q;
    assign lab.r = r_q;
    assign lab.d = d_q;
    assign lab.g = g_q;

    // The D paths are always compared; the SR paths only after a set or reset has
    // defined the storage state, since the power-up state of the latch is unknown.
    assign mism = (lab.q_latch != d_q) || (lab.q_ff != d_q) ||
                  (mv && ((lab.qa != m) || (lab.qb != ~m) || (lab.q_lvl != m)));

    assign pass = done && (err_count == '0);

    always_ff @(posedge ck) begin
        if (rst) begin
            state            <= IDLE;
            phase            <= 2'd0;
            m                <= 1'b0;
            mv               <= 1'b0;
            fail             <= 1'b0;
            s_q              <= 1'b0;
            r_q              <= 1'b0;
            d_q              <= 1'b0;
            g_q              <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            vec_idx          <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state               <= RUN;
                        busy                <= 1'b1;
                        done                <= 1'b0;
                        phase               <= 2'd0;
                        vec_idx             <= '0;
                        err_count           <= '0;
                        first_fail_valid    <= 1'b0;
                        first_fail_idx      <= '0;
                        m                   <= 1'b0;
                        mv                  <= 1'b0;
                        fail                <= 1'b0;
                        {s_q, r_q, d_q}     <= stim('0);
                        g_q                 <= 1'b0;
                    end
                end
                RUN: begin
                    phase <= phase + 2'd1;
                    case (phase)
                        2'd0: begin
                            // Rising gate edge next; the model follows s/r now.
                            g_q  <= 1'b1;
                            fail <= 1'b0;
                            if (s_q) begin
                                m  <= 1'b1;
                                mv <= 1'b1;
                            end else if (r_q) begin
                                m  <= 1'b0;
                                mv <= 1'b1;
                            end
                        end
                        2'd1: ;
                        2'd2: begin
                            g_q  <= 1'b0;
                            fail <= fail | mism;
                        end
                        default: begin
                            // Record the vector, folding in this edge's own check.
                            if (fail || mism) begin
                                if (err_count != ERR_MAX)
                                    err_count <= err_count + 1'b1;
                                if (!first_fail_valid) begin
                                    first_fail_valid <= 1'b1;
                                    first_fail_idx   <= vec_idx;
                                end
                            end
                            if (vec_idx == LAST_IDX) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                s_q   <= 1'b0;
                                r_q   <= 1'b0;
                                d_q   <= 1'b0;
                                g_q   <= 1'b0;
                            end else begin
                                vec_idx         <= vec_idx + 1'b1;
                                {s_q, r_q, d_q} <= stim(IDX_W'(vec_idx + 1'b1));
                            end
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_exerciser.sv
module tb_latch_exerciser;

    logic ck = 1'b0;
    logic rst;
    logic start;
    always #5 ck = ~ck;

    // Fault selectors for the lab top attached to the main instance.
    logic f_qff0;   // q_ff stuck at 0
    logic f_qbqa;   // qb follows qa instead of its complement

    latch_exerciser_if ifa();
    latch_exerciser_if ifb();

    logic       busy_a, done_a, pass_a, ffv_a;
    logic [7:0] err_a;
    logic [3:0] ffi_a, idx_a;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [1:0] err_b;
    logic [3:0] ffi_b, idx_b;

    latch_exerciser #(.IDX_W(4), .ERR_W(8)) dut_a (
        .ck(ck), .rst(rst), .start(start), .lab(ifa.master),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_valid(ffv_a), .first_fail_idx(ffi_a), .vec_idx(idx_a)
    );

    // Narrow error counter; its lab top has q_latch stuck at 1.
    latch_exerciser #(.IDX_W(4), .ERR_W(2)) dut_b (
        .ck(ck), .rst(rst), .start(start), .lab(ifb.master),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_valid(ffv_b), .first_fail_idx(ffi_b), .vec_idx(idx_b)
    );

    // Behavioural lab top A: SR latch, gated SR latch, D latch, D flip-flop on g.
    logic sr_a, lvl_a, lat_a, ff_a;
    always_latch if (ifa.s) sr_a = 1'b1; else if (ifa.r) sr_a = 1'b0;
    always_latch if (ifa.g && ifa.s) lvl_a = 1'b1; else if (ifa.g && ifa.r) lvl_a = 1'b0;
    always_latch if (ifa.g) lat_a = ifa.d;
    always_ff @(posedge ifa.g) ff_a <= ifa.d;
    assign ifa.qa      = sr_a;
    assign ifa.qb      = f_qbqa ? sr_a : ~sr_a;
    assign ifa.q_lvl   = lvl_a;
    assign ifa.q_latch = lat_a;
    assign ifa.q_ff    = f_qff0 ? 1'b0 : ff_a;

    // Lab top B: ideal except q_latch.
    logic sr_b, lvl_b, ff_b;
    always_latch if (ifb.s) sr_b = 1'b1; else if (ifb.r) sr_b = 1'b0;
    always_latch if (ifb.g && ifb.s) lvl_b = 1'b1; else if (ifb.g && ifb.r) lvl_b = 1'b0;
    always_ff @(posedge ifb.g) ff_b <= ifb.d;
    assign ifb.qa      = sr_b;
    assign ifb.qb      = ~sr_b;
    assign ifb.q_lvl   = lvl_b;
    assign ifb.q_latch = 1'b1;
    assign ifb.q_ff    = ff_b;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Start is sampled on the edge between the two negedges; returns in cycle 0 of RUN.
    task automatic pulse_start();
        @(negedge ck); start = 1'b1;
        @(negedge ck); start = 1'b0;
    endtask

    // Counts busy cycles (already in cycle 0) until busy drops; bounded.
    task automatic wait_done(input int restart_at, output int cycles);
        cycles = 0;
        while (busy_a && cycles < 200) begin
            start = (cycles == restart_at);
            cycles++;
            @(negedge ck);
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic qff0;
        logic qbqa;
        int   exp_err;
        int   exp_ffv;
        int   exp_ffi;
        int   exp_pass;
    } run_vec_t;

    run_vec_t   runs [3];
    logic [2:0] exp_srd [16];   // {s, r, d} per vector index, worked out by hand
    int         cyc;

    initial begin
        runs[0] = '{qff0: 1'b0, qbqa: 1'b0, exp_err: 0,  exp_ffv: 0, exp_ffi: 0, exp_pass: 1};
        runs[1] = '{qff0: 1'b1, qbqa: 1'b0, exp_err: 8,  exp_ffv: 1, exp_ffi: 1, exp_pass: 0};
        runs[2] = '{qff0: 1'b0, qbqa: 1'b1, exp_err: 14, exp_ffv: 1, exp_ffi: 2, exp_pass: 0};
        exp_srd[0]  = 3'b000; exp_srd[1]  = 3'b001; exp_srd[2]  = 3'b100; exp_srd[3]  = 3'b101;
        exp_srd[4]  = 3'b010; exp_srd[5]  = 3'b011; exp_srd[6]  = 3'b000; exp_srd[7]  = 3'b001;
        exp_srd[8]  = 3'b001; exp_srd[9]  = 3'b000; exp_srd[10] = 3'b101; exp_srd[11] = 3'b100;
        exp_srd[12] = 3'b011; exp_srd[13] = 3'b010; exp_srd[14] = 3'b001; exp_srd[15] = 3'b000;

        rst = 1'b1; start = 1'b0; f_qff0 = 1'b0; f_qbqa = 1'b0;
        repeat (3) @(negedge ck);
        check("reset_busy", 32'(busy_a), 0);
        check("reset_done", 32'(done_a), 0);
        check("reset_pass", 32'(pass_a), 0);
        check("reset_err",  32'(err_a), 0);
        check("reset_ffv",  32'(ffv_a), 0);
        check("reset_idx",  32'(idx_a), 0);
        check("reset_srdg", 32'({ifa.s, ifa.r, ifa.d, ifa.g}), 0);

        // rst and start together: rst wins.
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        check("rst_beats_start", 32'(busy_a), 0);
        rst = 1'b0;

        // Stimulus pattern over a full fault-free run.
        pulse_start();
        for (int k = 0; k < 64; k++) begin
            check($sformatf("stim_k%0d", k), 32'({ifa.s, ifa.r, ifa.d, ifa.g, idx_a}),
                  32'({exp_srd[k/4], (k%4 == 1) || (k%4 == 2), 4'(k/4)}));
            @(negedge ck);
        end
        check("stim_run_done", 32'(done_a), 1);
        check("done_srdg_idle", 32'({ifa.s, ifa.r, ifa.d, ifa.g}), 0);

        // Table-driven runs with injected lab-top faults.
        for (int i = 0; i < 3; i++) begin
            f_qff0 = runs[i].qff0;
            f_qbqa = runs[i].qbqa;
            pulse_start();
            wait_done(-1, cyc);
            f_qff0 = 1'b0; f_qbqa = 1'b0;
            check($sformatf("run%0d_cycles", i), 32'(cyc), 64);
            check($sformatf("run%0d_done", i), 32'(done_a), 1);
            check($sformatf("run%0d_pass", i), 32'(pass_a), 32'(runs[i].exp_pass));
            check($sformatf("run%0d_err", i), 32'(err_a), 32'(runs[i].exp_err));
            check($sformatf("run%0d_ffv", i), 32'(ffv_a), 32'(runs[i].exp_ffv));
            check($sformatf("run%0d_ffi", i), 32'(ffi_a), 32'(runs[i].exp_ffi));
            check($sformatf("run%0d_vidx", i), 32'(idx_a), 15);
            check($sformatf("run%0d_b_err_sat", i), 32'(err_b), 3);
            check($sformatf("run%0d_b_ffi", i), 32'({ffv_b, ffi_b}), 32'({1'b1, 4'd0}));
            check($sformatf("run%0d_b_pass", i), 32'({done_b, pass_b}), 32'(2'b10));
        end

        // Start from DONE clears the previous (failing) results; a second start
        // during the run is ignored.
        repeat (5) @(negedge ck);
        check("done_holds_err", 32'(err_a), 14);
        pulse_start();
        check("restart_busy", 32'({busy_a, done_a}), 32'(2'b10));
        check("restart_cleared", 32'({err_a, ffv_a, ffi_a}), 0);
        wait_done(20, cyc);
        check("restart_ignored_cycles", 32'(cyc), 64);
        check("restart_result", 32'({done_a, pass_a, err_a, ffv_a}), 32'({2'b11, 8'd0, 1'b0}));

        // rst mid-run drops partial results.
        f_qff0 = 1'b1;
        pulse_start();
        repeat (30) @(negedge ck);
        check("midrun_partial_err", 32'(err_a), 3);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        f_qff0 = 1'b0;
        check("midrun_rst_busy", 32'({busy_a, done_a}), 0);
        check("midrun_rst_srdg", 32'({ifa.s, ifa.r, ifa.d, ifa.g}), 0);
        check("midrun_rst_err", 32'({err_a, ffv_a, idx_a}), 0);
        @(negedge ck);
        check("midrun_stays_idle", 32'(busy_a), 0);
        pulse_start();
        wait_done(-1, cyc);
        check("after_rst_cycles", 32'(cyc), 64);
        check("after_rst_result", 32'({done_a, pass_a, err_a}), 32'({2'b11, 8'd0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/latch_exerciser.md
Name: latch_exerciser

Overview:
- Self-running stimulus generator and response checker for the lab's latch/flip-flop top.
- Drives the top's set, reset, data and gate inputs (the gate output connects to the top's ck input) from an internal vector sequence.
- Samples the five storage-element outputs and compares them against an internal behavioural model.
- Reports the mismatch count, the first failing vector and pass/fail, so the lab board can show a self-test result on LEDs.

Parameters:
- IDX_W, 4, vector index width; number of vectors N_VEC = 2**IDX_W.
- ERR_W, 8, error counter width; the counter saturates at 2**ERR_W-1.

Ports:
- ck  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE or DONE.
- qa  input  1  SR latch Q from the DUT.
- qb  input  1  SR latch Q-bar from the DUT.
- q_lvl  input  1  level-sensitive SR latch output.
- q_latch  input  1  transparent D latch output.
- q_ff  input  1  D flip-flop output.
- s  output  1  set stimulus, registered.
- r  output  1  reset stimulus, registered.
- d  output  1  data stimulus, registered.
- g  output  1  gate/clock stimulus to the DUT ck input, registered.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  equals done & (err_count==0).
- err_count  output  ERR_W  number of failing vectors, saturating.
- first_fail_valid  output  1  a failing vector has been recorded in this run.
- first_fail_idx  output  IDX_W  index of the first failing vector.
- vec_idx  output  IDX_W  current vector index.

Behaviour:
- Reset: all outputs 0; state=IDLE; phase=0; model bit m=0; model-valid flag mv=0.
- States:
  - IDLE: start -> RUN.
  - RUN: advances by itself; start is ignored.
  - DONE: start -> RUN.
- On entry to RUN (the edge that samples start): vec_idx=0, phase=0, err_count=0, first_fail_valid=0, first_fail_idx=0, mv=0, m=0.
- Each vector occupies exactly 4 ck cycles, phases 0..3.
- Stimulus for index i, applied from phase 0 and held through phase 3:
  - s = i[1] & ~i[2]
  - r = i[2] & ~i[1]
  - d = i[0] ^ i[3]
  - s=r=1 is never generated.
- Gate: g=0 in phases 0 and 3; g=1 in phases 1 and 2. Each vector therefore gives one rising edge of g (start of phase 1) and one falling edge (start of phase 3).
- Model update, on the edge ending phase 0:
  - if s: m=1 and mv=1
  - if r: m=0 and mv=1
  - otherwise m and mv hold.
- Checks are performed on the edges ending phase 2 and phase 3:
  - q_latch == d and q_ff == d: always checked.
  - qa == m, qb == ~m, q_lvl == m: checked only when mv=1.
- Per-vector fail flag: OR of all mismatches seen in phases 2 and 3. It is cleared at phase 0.
- Error recording, on the edge ending phase 3:
  - if the fail flag is set (including a mismatch detected on that same edge): err_count increments, saturating at its maximum.
  - if first_fail_valid=0 at that point: first_fail_idx = vec_idx and first_fail_valid = 1.
  - at most one increment per vector.
- Advance, on the edge ending phase 3:
  - if vec_idx == N_VEC-1: state -> DONE; s, r, d, g = 0; vec_idx holds at N_VEC-1.
  - otherwise: vec_idx increments and phase returns to 0.
- Latency: start sampled at edge t -> done rises at edge t + 4*N_VEC (64 edges for the defaults). busy is high in exactly the cycles between these edges.
- DONE results (err_count, first_fail_*, pass) hold until the next start or rst.
- rst mid-run: state returns to IDLE on that edge with all outputs 0. No partial results are retained.
- rst and start asserted together: rst wins.

Test Plan:
- Correct DUT (latch top instantiated, g tied to its ck), pulse start -> busy for 64 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
- q_ff forced to 0 -> vectors with d=1 fail (i=1,3,5,7,8,10,12,14) -> err_count=8, first_fail_idx=1, pass=0.
- qb forced equal to qa -> every vector from i=2 onward fails (mv set at i=2) -> err_count=14, first_fail_idx=2.
- ERR_W=2 with q_latch forced to 1 -> 8 failing vectors (d=0 cases) -> err_count saturates at 3, first_fail_idx=0.
- start pulsed again at cycle 20 of a run -> ignored, done still at edge 64. Then start in DONE -> results cleared, new run with identical results.
- rst asserted at cycle 30 of a run -> next cycle IDLE with s=r=d=g=0, busy=0, err_count=0. A subsequent start completes normally.
